// File: rtl/frame_buffer_pkg.sv
// Shared geometry, types and helpers for the ping-pong frame store.
// Cell addressing is row-major: addr = y*COLS + x.
package frame_buffer_pkg;

  localparam int COLS    = 160;
  localparam int ROWS    = 120;
  localparam int COLOR_W = 12;
  localparam int DEPTH   = COLS * ROWS;
  localparam int ADDR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  function automatic addr_t cell_addr(
    input logic [7:0] x,
    input logic [6:0] y
  );
    return addr_t'(y) * addr_t'(COLS) + addr_t'(x);
  endfunction

  function automatic logic in_range(
    input logic [7:0] x,
    input logic [6:0] y
  );
    return (x < 8'(COLS)) && (y < 7'(ROWS));
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// One frame buffer: single write port, registered read port.
// Contents are not reset.
module fb_dpram
  import frame_buffer_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  color_t wdata,
  input  logic   re,
  input  addr_t  raddr,
  output color_t rdata
);

  color_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_double_buffer.sv
// Ping-pong frame store in front of the VGA controller; the back buffer
// is written or cleared, and committed frames swap on a refresh rising edge.
module frame_double_buffer
  import frame_buffer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         refresh,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [7:0]   wr_x,
  input  logic [6:0]   wr_y,
  input  color_t       wr_color,
  input  logic         commit,
  input  logic         clr_start,
  input  color_t       clr_color,
  input  logic         rd_en,
  input  logic [7:0]   rd_x,
  input  logic [6:0]   rd_y,
  output color_t       rd_color,
  output logic         rd_valid,
  output logic         front_sel,
  output logic         swap_pending,
  output logic [15:0]  frame_count,
  output logic         err_oob
);

  fb_state_t state, nxt;
  logic [2:0] ref_q;
  logic       refresh_rise;
  addr_t      clr_addr;
  color_t     clr_q;
  logic       cmt_q;
  logic       rd_sel, rd_live;
  color_t     qa, qb;

  assign refresh_rise = ref_q[1] & ~ref_q[2];

  logic   clearing, last_clr;
  logic   wr_fire, wr_ok, rd_ok;
  logic   bwe;
  addr_t  baddr, raddr;
  color_t bdata;

  assign clearing = (state == CLEAR);
  assign last_clr = (clr_addr == addr_t'(DEPTH - 1));
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_ok    = in_range(wr_x, wr_y);
  assign rd_ok    = in_range(rd_x, rd_y);
  assign bwe      = clearing || (wr_fire && wr_ok);
  assign baddr    = clearing ? clr_addr : cell_addr(wr_x, wr_y);
  assign bdata    = clearing ? clr_q : wr_color;
  assign raddr    = cell_addr(rd_x, rd_y);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (clr_start)
          nxt = CLEAR;
        else if (commit)
          nxt = WAIT_SWAP;
      end
      CLEAR: begin
        if (last_clr)
          nxt = (cmt_q || commit) ? WAIT_SWAP : IDLE;
      end
      WAIT_SWAP: begin
        if (refresh_rise)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q       <= '0;
      state       <= IDLE;
      wr_ready    <= 1'b0;
      clr_addr    <= '0;
      clr_q       <= '0;
      cmt_q       <= 1'b0;
      front_sel   <= 1'b0;
      frame_count <= '0;
      err_oob     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
      rd_live     <= 1'b0;
    end else begin
      ref_q    <= {ref_q[1:0], refresh};
      state    <= nxt;
      wr_ready <= (nxt == IDLE);
      if (state == IDLE && clr_start) begin
        clr_addr <= '0;
        clr_q    <= clr_color;
      end else if (clearing) begin
        clr_addr <= clr_addr + addr_t'(1);
      end
      // commit seen during a clear is held until the fill completes
      cmt_q <= clearing && !last_clr && (cmt_q || commit);
      if (state == WAIT_SWAP && refresh_rise) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + 16'd1;
      end
      if ((wr_fire && !wr_ok) || (rd_en && !rd_ok))
        err_oob <= 1'b1;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel  <= front_sel;
        rd_live <= rd_ok;
      end
    end
  end

  assign swap_pending = (state == WAIT_SWAP) || (clearing && cmt_q);
  assign rd_color     = rd_live ? (rd_sel ? qb : qa) : '0;

  // back buffer is the one not on display
  fb_dpram u_a (
    .clk   (clk),
    .we    (bwe && front_sel),
    .waddr (baddr),
    .wdata (bdata),
    .re    (rd_en && rd_ok && !front_sel),
    .raddr (raddr),
    .rdata (qa)
  );

  fb_dpram u_b (
    .clk   (clk),
    .we    (bwe && !front_sel),
    .waddr (baddr),
    .wdata (bdata),
    .re    (rd_en && rd_ok && front_sel),
    .raddr (raddr),
    .rdata (qb)
  );

endmodule

// File: tb/tb_frame_double_buffer.sv
// Scenario bench for frame_double_buffer: read data checked via a
// scoreboard of expected colors popped when rd_valid appears.
module tb_frame_double_buffer;
  import frame_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, refresh, wr_valid, commit, clr_start, rd_en;
  logic [7:0]  wr_x, rd_x;
  logic [6:0]  wr_y, rd_y;
  color_t      wr_color, clr_color, rd_color;
  logic        wr_ready, rd_valid, front_sel, swap_pending, err_oob;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  color_t exp_q[$];
  color_t mdl [2][DEPTH];
  int fs_m = 0;
  int fc_m = 0;

  frame_double_buffer dut (
    .clk(clk), .reset(reset), .refresh(refresh),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .commit(commit), .clr_start(clr_start), .clr_color(clr_color),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_color(rd_color), .rd_valid(rd_valid),
    .front_sel(front_sel), .swap_pending(swap_pending),
    .frame_count(frame_count), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : mon
    color_t e;
    #1;
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %03h with empty scoreboard", rd_color);
      end else begin
        e = exp_q.pop_front();
        if (rd_color !== e) begin
          errors++;
          $display("FAIL rd_color got %03h exp %03h", rd_color, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int x, input int y, input color_t c);
    int n = 0;
    wr_x = 8'(x); wr_y = 7'(y); wr_color = c; wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept x=%0d y=%0d wr_ready got %b exp 1", x, y, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    if (x < COLS && y < ROWS)
      mdl[1-fs_m][y*COLS+x] = c;
  endtask

  task automatic do_read(input int x, input int y);
    rd_x = 8'(x); rd_y = 7'(y); rd_en = 1'b1;
    if (x < COLS && y < ROWS)
      exp_q.push_back(mdl[fs_m][y*COLS+x]);
    else
      exp_q.push_back('0);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick(4);
    refresh = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1; refresh = 0; wr_valid = 0; commit = 0; clr_start = 0;
    rd_en = 0; wr_x = 0; wr_y = 0; rd_x = 0; rd_y = 0;
    wr_color = 0; clr_color = 0;
    tick(3);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    checks++; if (rd_color !== 12'h000) begin errors++; $display("FAIL reset_rd_color got %03h exp 000", rd_color); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got %b exp 0", front_sel); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got %b exp 0", swap_pending); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob got %b exp 0", err_oob); end
    reset = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_commit_swap();
    do_write(10, 5, 12'hF00);
    do_write(3, 3, 12'h0AA);
    do_commit();
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL t1_swap_pending got %b exp 1", swap_pending); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL t1_wr_ready_wait got %b exp 0", wr_ready); end
    pulse_refresh();
    fs_m = 1; fc_m = 1;
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL t1_front_sel got %b exp 1", front_sel); end
    checks++; if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL t1_frame_count got %0d exp %0d", frame_count, fc_m); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL t1_swap_cleared got %b exp 0", swap_pending); end
    do_read(10, 5);
    do_read(3, 3);
    tick(2);
  endtask

  task automatic test_no_commit();
    do_write(3, 3, 12'h0F0);
    repeat (5) pulse_refresh();
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t2_front_sel got %b exp %0d", front_sel, fs_m); end
    checks++; if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL t2_frame_count got %0d exp %0d", frame_count, fc_m); end
    do_read(3, 3);
    tick(2);
  endtask

  task automatic test_clear();
    int ready_bad = 0;
    clr_color = 12'h00F;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) mdl[1-fs_m][a] = 12'h00F;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ready !== 1'b0) ready_bad++;
      if (i == 150) begin
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL t3_pending_mid_clear got %b exp 1", swap_pending); end
      end
      commit = (i == 100);
      clr_start = (i == 200);
      tick();
    end
    commit = 1'b0; clr_start = 1'b0;
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL t3_wr_ready_busy got %0d ready cycles exp 0", ready_bad); end
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL t3_pending_after_clear got %b exp 1", swap_pending); end
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t3_no_early_swap got %b exp %0d", front_sel, fs_m); end
    pulse_refresh();
    fs_m = 1 - fs_m; fc_m++;
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t3_front_sel got %b exp %0d", front_sel, fs_m); end
    checks++; if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL t3_frame_count got %0d exp %0d", frame_count, fc_m); end
    do_read(0, 0);
    do_read(159, 119);
    do_read(10, 5);
    do_read(3, 3);
    do_read(80, 60);
    do_read(0, 1);
    tick(2);
  endtask

  task automatic test_oob();
    do_write(0, 1, 12'h123);
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL t4_err_oob_early got %b exp 0", err_oob); end
    do_write(160, 0, 12'hFFF);
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL t4_err_oob_write got %b exp 1", err_oob); end
    do_read(0, 120);
    tick(2);
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL t4_err_oob_sticky got %b exp 1", err_oob); end
    do_commit();
    pulse_refresh();
    fs_m = 1 - fs_m; fc_m++;
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t4_front_sel got %b exp %0d", front_sel, fs_m); end
    do_read(0, 1);
    do_read(10, 5);
    tick(2);
  endtask

  task automatic test_commit_on_rise();
    refresh = 1'b1;
    tick(2);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(3);
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t5_no_swap_same_edge got %b exp %0d", front_sel, fs_m); end
    checks++; if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL t5_count_same_edge got %0d exp %0d", frame_count, fc_m); end
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL t5_pending got %b exp 1", swap_pending); end
    refresh = 1'b0;
    tick(4);
    pulse_refresh();
    fs_m = 1 - fs_m; fc_m++;
    checks++; if (front_sel !== 1'(fs_m)) begin errors++; $display("FAIL t5_swap_next_edge got %b exp %0d", front_sel, fs_m); end
    checks++; if (frame_count !== 16'(fc_m)) begin errors++; $display("FAIL t5_count_next_edge got %0d exp %0d", frame_count, fc_m); end
  endtask

  task automatic test_reset_wait_swap();
    if (fs_m == 0) begin
      do_commit();
      pulse_refresh();
      fs_m = 1; fc_m++;
    end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL t6_pre_front_sel got %b exp 1", front_sel); end
    do_commit();
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL t6_pre_pending got %b exp 1", swap_pending); end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    fs_m = 0; fc_m = 0;
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL t6_front_sel got %b exp 0", front_sel); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL t6_pending got %b exp 0", swap_pending); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL t6_frame_count got %0d exp 0", frame_count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL t6_wr_ready got %b exp 1", wr_ready); end
    pulse_refresh();
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL t6_dropped_commit got %b exp 0", front_sel); end
  endtask

  initial begin
    test_reset();
    test_commit_swap();
    test_no_commit();
    test_clear();
    test_oob();
    test_commit_on_rise();
    test_reset_wait_swap();
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing got %0d outstanding exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
